skid_latch_nbit: RTL and testbench
==================================

SKID_LATCH_NBIT -- requirements
Module: skid_latch_nbit

Interface
REQ-001 SHALL have parameter N, default 8, data width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  upstream word present on in_data.
REQ-005 SHALL have port in_ready  output  1  block can accept a word this cycle.
REQ-006 SHALL have port in_data  input  N  upstream word (e.g. nand-stage operand).
REQ-007 SHALL have port flush  input  1  synchronous discard of all held words.
REQ-008 SHALL have port out_valid  output  1  word present on out_data.
REQ-009 SHALL have port out_ready  input  1  downstream (nand-stage consumer) takes word.
REQ-010 SHALL have port out_data  output  N  oldest held word.
REQ-011 SHALL have port out_par  output  1  even parity of out_data; present only with SKID_LATCH_PARITY_EN.

Function
REQ-012 SHALL be a 2-entry in-order pipeline latch with skid slot; states EMPTY, ONE, FULL held in a registered state field.
REQ-013 SHALL accept a word when in_valid && in_ready at a rising edge, and deliver a word when out_valid && out_ready at a rising edge.
REQ-014 SHALL drive in_ready = (state != FULL) and out_valid = (state != EMPTY), both purely from registered state (no combinational in->out paths).
REQ-015 SHALL transition EMPTY->ONE on accept; ONE->FULL on accept without deliver; ONE->EMPTY on deliver without accept; ONE->ONE on simultaneous accept+deliver; FULL->ONE on deliver; all other cases hold state.
REQ-016 SHALL present an accepted word on out_data with out_valid=1 exactly one cycle after acceptance when empty (latency 1).
REQ-017 SHALL preserve order: out_data always the oldest undelivered word; skid word moves to head on FULL->ONE in the same edge.
REQ-018 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-019 SHALL ignore in_valid while in_ready=0 (no overwrite when FULL).
REQ-020 SHALL, on flush=1, go to EMPTY at the next edge, drop both held words and any concurrent accept; concurrent deliver still counts as delivered downstream; flush dominates all other events.
REQ-021 SHALL not alter the data registers of invalid slots observably: out_data when out_valid=0 is don't-care but SHALL be the last head value, not X after reset.

Reset
REQ-022 SHALL on rst_n=0 immediately set state=EMPTY, out_valid=0, in_ready=1, out_data=0, out_par=0, independent of clk.
REQ-023 SHALL leave reset on the first rising clk edge after rst_n rises; an in_valid on that edge is accepted.
REQ-024 SHALL discard held words when reset asserts mid-operation, with no partial delivery.

Configuration
REQ-025 SHALL, with macro SKID_LATCH_PARITY_EN defined, store one parity bit per entry computed at accept (XOR of in_data) and drive out_par alongside out_data with identical timing.
REQ-026 SHALL, without SKID_LATCH_PARITY_EN, omit out_par and parity storage entirely; all other behaviour identical.

Structure
REQ-027 SHALL take the state encoding (EMPTY=2'b00, ONE=2'b01, FULL=2'b10) and default width constant from shared package skid_latch_pkg.
REQ-028 SHALL build head and skid storage from one sub-module reg_nbit (N-bit, load-enabled, async active-low clear register) instantiated twice.
REQ-029 SHALL treat state 2'b11 as illegal, recovering to EMPTY on the next edge.

Verification
REQ-030 SHALL cover: reset, then in_data=8'hA5 valid one cycle, out_ready=1 -> out_valid=1 with 8'hA5 next cycle, EMPTY after.
REQ-031 SHALL cover: out_ready=0, push 8'h11,8'h22 -> in_ready=0 after second; then out_ready=1 -> 8'h11 then 8'h22, in_ready=1 after first deliver.
REQ-032 SHALL cover: streaming 8'h01..8'h10 with out_ready=1 every cycle -> 16 words in order, in_ready never 0, throughput 1/cycle.
REQ-033 SHALL cover: FULL with 8'h33,8'h44, flush=1 plus in_valid with 8'h55 -> next cycle EMPTY, 8'h55 never emitted.
REQ-034 SHALL cover: rst_n low mid-stream between edges -> out_valid=0, out_data=0 immediately, in_ready=1.
REQ-035 SHALL cover (SKID_LATCH_PARITY_EN): push 8'h07 then 8'h03 -> out_par=1 then 0.

Source files
------------

// File: rtl/skid_latch_pkg.sv
// Shared definitions for the skid_latch_nbit pipeline latch.
//   state_e    : registered occupancy state (EMPTY / ONE / FULL).
//   DEFAULT_N  : default data width.
// Optional feature macro used by this codebase: SKID_LATCH_PARITY_EN.
package skid_latch_pkg;

  localparam int DEFAULT_N = 8;

  // 2'b11 is not a legal state; the latch recovers from it to EMPTY.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } state_e;

endpackage

// File: rtl/skid_latch_nbit_if.sv
// Handshake bundle for skid_latch_nbit.
//   Upstream  : in_valid, in_ready, in_data, flush
//   Downstream: out_valid, out_ready, out_data, out_par (only with
//               SKID_LATCH_PARITY_EN)
// Handshake: a word moves across a side at a rising clk edge where both
// valid and ready are 1; valid never waits on ready, and ready/valid of the
// latch depend only on its registered state.
// Modports: slave = the latch, master = the environment driving it.
interface skid_latch_nbit_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
`ifdef SKID_LATCH_PARITY_EN
  logic         out_par;
`endif

  modport slave (
    input  in_valid, in_data, flush, out_ready,
`ifdef SKID_LATCH_PARITY_EN
    output out_par,
`endif
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, flush, out_ready,
`ifdef SKID_LATCH_PARITY_EN
    input  out_par,
`endif
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/reg_nbit.sv
// W-bit load-enabled register with asynchronous active-low clear.
//   clk, rst_n : clock, async clear to zero
//   en         : load d at the rising edge
//   d, q       : data in / registered data out
module reg_nbit #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (en) data_d = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign q = data_q;
endmodule

// File: rtl/skid_latch_nbit.sv
// 2-entry in-order pipeline latch with a skid slot.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : skid_latch_nbit_if slave (in_*, flush, out_*)
//   state_dbg  : registered occupancy state, for observation
// The head register always holds the oldest word and drives out_data; the
// skid register catches a second word while the head is stalled.
// With SKID_LATCH_PARITY_EN defined, each entry also stores the XOR of its
// data taken at accept, driven out as out_par with out_data timing.
module skid_latch_nbit
  import skid_latch_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic                  clk,
  input  logic                  rst_n,
  skid_latch_nbit_if.slave      bus,
  output state_e                state_dbg
);
`ifdef SKID_LATCH_PARITY_EN
  localparam int W = N + 1;
`else
  localparam int W = N;
`endif

  state_e       state_q;
  state_e       state_d;
  logic         accept;
  logic         deliver;
  logic         head_en;
  logic         skid_en;
  logic [W-1:0] head_d;
  logic [W-1:0] head_q;
  logic [W-1:0] skid_q;
  logic [W-1:0] in_entry;

`ifdef SKID_LATCH_PARITY_EN
  assign in_entry = {^bus.in_data, bus.in_data};
`else
  assign in_entry = bus.in_data;
`endif

  // Handshake outputs come only from registered state.
  assign bus.in_ready  = (state_q != ST_FULL);
  assign bus.out_valid = (state_q != ST_EMPTY);

  assign accept  = bus.in_valid && bus.in_ready;
  assign deliver = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    head_en = 1'b0;
    skid_en = 1'b0;
    head_d  = in_entry;
    if (bus.flush) begin
      // Flush wins: no loads, so the concurrent accept is dropped and the
      // head keeps its last value for out_data.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            head_en = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && deliver) begin
            head_en = 1'b1;
          end else if (accept) begin
            state_d = ST_FULL;
            skid_en = 1'b1;
          end else if (deliver) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (deliver) begin
            // Skid word becomes the head on the same edge.
            state_d = ST_ONE;
            head_en = 1'b1;
            head_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  reg_nbit #(.W(W)) u_head (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (head_en),
    .d     (head_d),
    .q     (head_q)
  );

  reg_nbit #(.W(W)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (skid_en),
    .d     (in_entry),
    .q     (skid_q)
  );

  assign bus.out_data = head_q[N-1:0];
`ifdef SKID_LATCH_PARITY_EN
  assign bus.out_par  = head_q[N];
`endif
  assign state_dbg    = state_q;
endmodule

// File: tb/tb_skid_latch_nbit.sv
module tb_skid_latch_nbit;
  import skid_latch_pkg::*;

  localparam int N = 8;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  state_e state_dbg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  skid_latch_nbit_if #(.N(N)) bus ();

  skid_latch_nbit #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int total;
  int bad;
  logic [N-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one active edge; inputs are driven and outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [N-1:0] d, input logic ordy, input logic fl);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  task automatic check_out(input string tag, input logic ov, input logic ir,
                           input logic [N-1:0] od, input logic [1:0] st);
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
    check({tag, ".in_ready"},  32'(bus.in_ready),  32'(ir));
    check({tag, ".out_data"},  32'(bus.out_data),  32'(od));
    check({tag, ".state"},     32'(state_dbg),     32'(st));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    #2;
    check_out("reset", 1'b0, 1'b1, 8'h00, 2'b00);
`ifdef SKID_LATCH_PARITY_EN
    check("reset.out_par", 32'(bus.out_par), 32'(0));
`endif
    tick();
    tick();
    rst_n = 1'b1;

    // Single word, latency 1, then empty again.
    drive(1'b1, 8'hA5, 1'b1, 1'b0);
    tick();
    check_out("single_a5", 1'b1, 1'b1, 8'hA5, 2'b01);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    check_out("single_empty", 1'b0, 1'b1, 8'hA5, 2'b00);

    // Stalled downstream: fill both slots, overflow attempt ignored.
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    tick();
    check_out("fill_11", 1'b1, 1'b1, 8'h11, 2'b01);
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    tick();
    check_out("fill_22", 1'b1, 1'b0, 8'h11, 2'b10);
    drive(1'b1, 8'h99, 1'b0, 1'b0);
    tick();
    check_out("full_hold", 1'b1, 1'b0, 8'h11, 2'b10);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    check_out("drain_22", 1'b1, 1'b1, 8'h22, 2'b01);
    tick();
    check_out("drain_empty", 1'b0, 1'b1, 8'h22, 2'b00);

    // Streaming 8'h01..8'h10 at one word per cycle.
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 8'(i), 1'b1, 1'b0);
      exp_q.push_back(8'(i));
      tick();
      check("stream.out_valid", 32'(bus.out_valid), 32'(1));
      check("stream.in_ready",  32'(bus.in_ready),  32'(1));
      check("stream.out_data",  32'(bus.out_data),  32'(exp_q.pop_front()));
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    check_out("stream_end", 1'b0, 1'b1, 8'h10, 2'b00);

    // Flush while full, with a concurrent offered word that must be dropped.
    drive(1'b1, 8'h33, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h44, 1'b0, 1'b0);
    tick();
    check_out("pre_flush", 1'b1, 1'b0, 8'h33, 2'b10);
    drive(1'b1, 8'h55, 1'b0, 1'b1);
    tick();
    check_out("flush", 1'b0, 1'b1, 8'h33, 2'b00);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    check_out("post_flush", 1'b0, 1'b1, 8'h33, 2'b00);

`ifdef SKID_LATCH_PARITY_EN
    // Parity: 8'h07 has three ones (odd -> 1), 8'h03 has two (-> 0).
    drive(1'b1, 8'h07, 1'b0, 1'b0);
    tick();
    check("par_07", 32'(bus.out_par), 32'(1));
    drive(1'b1, 8'h03, 1'b0, 1'b0);
    tick();
    check("par_07_held", 32'(bus.out_par), 32'(1));
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    check("par_03", 32'(bus.out_par), 32'(0));
    check("par_03.data", 32'(bus.out_data), 32'(8'h03));
    tick();
    check("par_empty", 32'(bus.out_valid), 32'(0));
`endif

    // Asynchronous reset mid-stream, between edges.
    drive(1'b1, 8'h66, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h77, 1'b0, 1'b0);
    tick();
    check_out("pre_reset", 1'b1, 1'b0, 8'h66, 2'b10);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check_out("async_reset", 1'b0, 1'b1, 8'h00, 2'b00);
`ifdef SKID_LATCH_PARITY_EN
    check("async_reset.out_par", 32'(bus.out_par), 32'(0));
`endif
    // Release away from the edge; the word on the first edge is accepted.
    rst_n = 1'b1;
    drive(1'b1, 8'h88, 1'b0, 1'b0);
    tick();
    check_out("post_reset_accept", 1'b1, 1'b1, 8'h88, 2'b01);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    check_out("post_reset_drain", 1'b0, 1'b1, 8'h88, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
